// File: rtl/clock_period_checker.sv
// Receive-side monitor for the derived clocks: measures every half period in clk_i
// cycles against the channel's programmed value and reports lock and sticky errors.
`timescale 1ns/1ps
module clock_period_checker #(
  parameter int NUM_CLK  = 13,
  parameter int HP_MAX   = 14,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               freeze,
  input  logic [NUM_CLK-1:0] clk_mon,
  input  logic               err_clr,
  output logic [NUM_CLK-1:0] locked,
  output logic [NUM_CLK-1:0] err,
  output logic               all_locked,
  output logic               err_any
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] half_period(input int idx);
    return CNT_W'(HP_MAX - idx);
  endfunction

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
    return (run == RUN_MAX) ? run : run + RUN_ONE;
  endfunction

  logic [NUM_CLK-1:0] prev_r;
  logic [NUM_CLK-1:0] armed_r;
  logic [NUM_CLK-1:0] to_r;
  logic [NUM_CLK-1:0] locked_r;
  logic [NUM_CLK-1:0] err_r;
  logic               all_locked_r;
  logic               err_any_r;
  logic [CNT_W-1:0]   cnt_r [NUM_CLK];
  logic [RUN_W-1:0]   run_r [NUM_CLK];

  logic [NUM_CLK-1:0] toggle_s;
  logic [NUM_CLK-1:0] armed_s;
  logic [NUM_CLK-1:0] to_s;
  logic [NUM_CLK-1:0] err_ev_s;
  logic [NUM_CLK-1:0] locked_s;
  logic [NUM_CLK-1:0] err_s;
  logic [CNT_W-1:0]   cnt_s [NUM_CLK];
  logic [CNT_W-1:0]   len_s [NUM_CLK];
  logic [RUN_W-1:0]   run_s [NUM_CLK];

  // Per-channel edge detection, half-period measurement and timeout detection
  always_comb begin
    for (int i = 0; i < NUM_CLK; i++) begin
      toggle_s[i] = clk_mon[i] ^ prev_r[i];
      armed_s[i]  = armed_r[i];
      to_s[i]     = to_r[i];
      cnt_s[i]    = cnt_r[i];
      run_s[i]    = run_r[i];
      err_ev_s[i] = 1'b0;
      len_s[i]    = cnt_r[i] + CNT_ONE;
      if (toggle_s[i]) begin
        if (armed_r[i]) begin
          cnt_s[i] = CNT_ZERO;
          to_s[i]  = 1'b0;
          if ((len_s[i] == half_period(i)) && !to_r[i]) begin
            run_s[i] = run_inc(run_r[i]);
          end else begin
            // a late edge after a flagged timeout restarts the run silently
            run_s[i]    = RUN_ZERO;
            err_ev_s[i] = ~to_r[i];
          end
        end else begin
          armed_s[i] = 1'b1;
          cnt_s[i]   = CNT_ZERO;
        end
      end else if (armed_r[i]) begin
        cnt_s[i] = (cnt_r[i] == CNT_SAT) ? cnt_r[i] : len_s[i];
        if ((len_s[i] == half_period(i)) && !to_r[i]) begin
          to_s[i]     = 1'b1;
          run_s[i]    = RUN_ZERO;
          err_ev_s[i] = 1'b1;
        end else begin
          to_s[i] = to_r[i];
        end
      end else begin
        cnt_s[i] = cnt_r[i];
      end
      locked_s[i] = (run_s[i] == RUN_MAX);
    end
    // a new error in the same cycle as err_clr wins
    err_s = (err_clr ? {NUM_CLK{1'b0}} : err_r) |
            (freeze ? {NUM_CLK{1'b0}} : err_ev_s);
  end

  // Channel state and status registers; freeze holds all but the error clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_r       <= {NUM_CLK{1'b0}};
      armed_r      <= {NUM_CLK{1'b0}};
      to_r         <= {NUM_CLK{1'b0}};
      locked_r     <= {NUM_CLK{1'b0}};
      err_r        <= {NUM_CLK{1'b0}};
      all_locked_r <= 1'b0;
      err_any_r    <= 1'b0;
      for (int i = 0; i < NUM_CLK; i++) begin
        cnt_r[i] <= CNT_ZERO;
        run_r[i] <= RUN_ZERO;
      end
    end else begin
      if (!freeze) begin
        prev_r       <= clk_mon;
        armed_r      <= armed_s;
        to_r         <= to_s;
        locked_r     <= locked_s;
        all_locked_r <= &locked_s;
        for (int i = 0; i < NUM_CLK; i++) begin
          cnt_r[i] <= cnt_s[i];
          run_r[i] <= run_s[i];
        end
      end else begin
        prev_r       <= prev_r;
        armed_r      <= armed_r;
        to_r         <= to_r;
        locked_r     <= locked_r;
        all_locked_r <= all_locked_r;
      end
      err_r     <= err_s;
      err_any_r <= |err_s;
    end
  end

  assign locked     = locked_r;
  assign err        = err_r;
  assign all_locked = all_locked_r;
  assign err_any    = err_any_r;

endmodule

// File: doc/clock_period_checker.md
# clock_period_checker

Receive-side monitor for the multi-clock generator's 13 derived clock outputs. Samples each derived clock in the `clk_i` domain and measures every half period in `clk_i` cycles. Checks each measurement against the channel's programmed half period. Reports per-channel lock and sticky error status, and sits beside the generator in testbenches and on-target self-check builds.

## Interface
- `NUM_CLK`, default 13: number of monitored clocks.
- `HP_MAX`, default 14: expected half period of channel 0; channel i expects `HP_i = HP_MAX - i` (14 down to 2).
- `LOCK_CNT`, default 4: consecutive correct half periods required to declare lock.
- `CNT_W`, default 5: width of the per-channel cycle counter; saturates at `2^CNT_W - 1`.
- `clk_i`  in  1: system clock, the same clock that drives the generator. One clock only.
- `rst_ni`  in  1: reset, asynchronous and active-low; clears all state.
- `freeze`  in  1: when 1, all internal state holds; same meaning as the generator's freeze.
- `clk_mon`  in  NUM_CLK: derived clocks, registered in the `clk_i` domain, so no synchronizer is used.
- `err_clr`  in  1: synchronous clear of `err`.
- `locked`  out  NUM_CLK: channel i has seen `LOCK_CNT` consecutive correct half periods since the last error.
- `err`  out  NUM_CLK: sticky; channel i has seen a wrong or missing edge.
- `all_locked`  out  1: AND of `locked`.
- `err_any`  out  1: OR of `err`.

## Operation
Per-channel state:
- `prev_i`: last sample of `clk_mon[i]`.
- `armed_i`: a first edge has been seen.
- `cnt_i`: cycles since the last edge.
- `run_i`: count of good half periods, 0..LOCK_CNT.
- `to_i`: a timeout has already been flagged.

Reset value of all state and all outputs is 0.

On each `clk_i` rising edge with `freeze`=0, for every channel:
- Update `prev_i` to `clk_mon[i]`. A toggle is `clk_mon[i] != prev_i`.
- **Toggle while not armed:**
  - Set `armed_i`; set `cnt_i` to 0.
  - No measurement is taken.
- **Toggle while armed:**
  - Measured length L = `cnt_i + 1`; then set `cnt_i` to 0 and `to_i` to 0.
  - If L == `HP_i` and `to_i`==0: `run_i` increments, saturating at `LOCK_CNT`.
  - Otherwise: `run_i` is set to 0 and `err[i]` is set.
- **No toggle while armed:**
  - `cnt_i` increments, saturating.
  - If `cnt_i + 1 == HP_i` and `to_i`==0, this is a timeout: set `to_i`, set `run_i` to 0, and set `err[i]`. The channel has been stuck for at least `HP_i` cycles.
  - The late edge that eventually arrives is not counted as good and does not re-flag, because `to_i` is set.
- **No toggle while not armed:** no change. A channel that never toggles is never flagged.

Output rules:
- `locked[i]` = (`run_i` == `LOCK_CNT`). It drops the cycle after any error event on that channel.
- `err_clr`=1 clears all `err` bits.
- If a new error event on channel i occurs in the same cycle as `err_clr`, `err[i]` ends at 1 (set wins).

With `freeze`=1, nothing updates, including `prev_i`. The generator freezes in lockstep, so no edges are lost. `err_clr` is still honoured during freeze.

Width rules:
- `HP_i` must be less than `2^CNT_W - 1`.
- Comparisons are unsigned, at `CNT_W` bits.

## Timing
- All outputs are registered, so status reflects events one cycle after the toggle or timeout cycle.
- Lock latency:
  - First toggle at cycle t0 arms the channel.
  - Toggles at t0 + k·HP_i, for k = 1..LOCK_CNT, are good.
  - `locked[i]` rises at the edge after cycle t0 + LOCK_CNT·HP_i.
- Error latency:
  - An early edge is flagged one cycle after that edge.
  - A missing edge is flagged one cycle after the cycle in which `cnt_i + 1` reaches `HP_i`.
- `rst_ni` low at any time clears everything immediately, independent of `clk_i`. After release every channel must re-arm; edges in flight are discarded.

## Test plan
- **Nominal:** drive a generator-equivalent model (channel i toggles every 14-i cycles) from reset. Required: `err`=0 throughout; `locked[12]` rises 1 cycle after the 5th channel-12 toggle (t0+8); `all_locked`=1 once channel 0 has logged 4 good 14-cycle halves (t0+56, +1). Bench checks every channel's rise time.
- **Early edge:** on channel 5 (HP 9), make one half period 8 cycles after lock. Required: `err[5]` and `err_any` rise 1 cycle after that edge; `locked[5]` falls; relock after 4 further good halves; other channels unaffected.
- **Stuck clock:** hold channel 12 constant after lock. Required: `err[12]` set exactly 1 cycle after the 2nd idle cycle; single flag; restart toggles and get relock after arming edge plus 4 good halves.
- **Freeze:** assert `freeze` for 20 cycles mid-run on model and DUT together. Required: no error, `locked` held constant, counters resume exactly.
- **Clear collision:** pulse `err_clr` in the same cycle as a new channel-3 error, while `err[0]` is already set. Required: after the edge, `err[0]`=0 and `err[3]`=1.
- **Reset mid-operation:** assert `rst_ni` low asynchronously while locked. Required: all outputs 0 immediately; after release, the first toggle per channel is not measured; relock timing as in the nominal case.
